// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 encodings, FSM state type and access checks for the lsu
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_MERGE = 1'b1
  } state_e;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) begin
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: return ~off[0];
      F3_W:        return (off == 2'b00);
      default:     return 1'b1;
    endcase
  endfunction

  // Drop the low offset bits a given size cannot use.
  function automatic logic [1:0] align_down(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: return {off[1], 1'b0};
      F3_W:        return 2'b00;
      default:     return off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - request/response and data memory signal bundle for the lsu
interface lsu_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;

  logic        mem_r_enable;
  logic        mem_w_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_re_data;

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_re_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
    input  mem_r_enable, mem_w_enable, mem_address, mem_wr_data
  );

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_re_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault,
    output mem_r_enable, mem_w_enable, mem_address, mem_wr_data
  );

endinterface

// File: rtl/lsu_lane.sv
// rtl/lsu_lane.sv - byte-lane extract/extend for loads and sub-word merge for stores
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] ld_word_i,
  input  logic [1:0]  ld_offset_i,
  input  logic [2:0]  ld_funct3_i,
  output logic [31:0] ld_rdata_o,
  input  logic [31:0] st_old_word_i,
  input  logic [15:0] st_wdata_i,
  input  logic [1:0]  st_offset_i,
  input  logic [2:0]  st_funct3_i,
  output logic [31:0] st_new_word_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = ld_word_i >> {ld_offset_i, 3'b000};
    case (ld_funct3_i)
      F3_B:    ld_rdata_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    ld_rdata_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    ld_rdata_o = shifted;
      F3_BU:   ld_rdata_o = {24'h0, shifted[7:0]};
      F3_HU:   ld_rdata_o = {16'h0, shifted[15:0]};
      default: ld_rdata_o = 32'h0;
    endcase
  end

  always_comb begin
    st_new_word_o = st_old_word_i;
    case (st_funct3_i)
      F3_B:    st_new_word_o[{st_offset_i, 3'b000} +: 8] = st_wdata_i[7:0];
      F3_H:    st_new_word_o[{st_offset_i[1], 4'b0000} +: 16] = st_wdata_i;
      default: st_new_word_o = st_old_word_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - RV32I load/store unit with sub-word read-modify-write stores
// Optional macro LSU_MISALIGN_TRAP_EN: fault misaligned accesses instead of aligning them down.
module lsu
  import lsu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  lsu_if.slave bus
);

  state_e      state_q, state_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_fault_q, rsp_fault_d;
  logic [29:0] cap_waddr_q, cap_waddr_d;
  logic [2:0]  cap_f3_q, cap_f3_d;
  logic [15:0] cap_wdata_q, cap_wdata_d;
  logic [1:0]  cap_off_q, cap_off_d;
  logic [31:0] cap_old_q, cap_old_d;

  logic        req_ready;
  logic        accept;
  logic        fault;
  logic [1:0]  req_off;
  logic [31:0] ld_rdata;
  logic [31:0] merged_word;

  logic        mem_r_enable;
  logic        mem_w_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wr_data;

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = bus.req_valid & req_ready;
  assign req_off   = align_down(bus.req_funct3, bus.req_addr[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
  assign fault = ~f3_legal(bus.req_store, bus.req_funct3) |
                 ~is_aligned(bus.req_funct3, bus.req_addr[1:0]);
`else
  assign fault = ~f3_legal(bus.req_store, bus.req_funct3);
`endif

  lsu_lane u_lane (
    .ld_word_i     (bus.mem_re_data),
    .ld_offset_i   (req_off),
    .ld_funct3_i   (bus.req_funct3),
    .ld_rdata_o    (ld_rdata),
    .st_old_word_i (cap_old_q),
    .st_wdata_i    (cap_wdata_q),
    .st_offset_i   (cap_off_q),
    .st_funct3_i   (cap_f3_q),
    .st_new_word_o (merged_word)
  );

  always_comb begin
    state_d      = state_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = 32'h0;
    rsp_fault_d  = 1'b0;
    cap_waddr_d  = cap_waddr_q;
    cap_f3_d     = cap_f3_q;
    cap_wdata_d  = cap_wdata_q;
    cap_off_d    = cap_off_q;
    cap_old_d    = cap_old_q;
    mem_r_enable = 1'b0;
    mem_w_enable = 1'b0;
    mem_address  = {bus.req_addr[31:2], 2'b00};
    mem_wr_data  = 32'h0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (fault) begin
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b1;
          end else if (!bus.req_store) begin
            mem_r_enable = 1'b1;
            rsp_valid_d  = 1'b1;
            rsp_rdata_d  = ld_rdata;
          end else if (bus.req_funct3 == F3_W) begin
            mem_w_enable = 1'b1;
            mem_wr_data  = bus.req_wdata;
            rsp_valid_d  = 1'b1;
          end else begin
            // Sub-word store: fetch the old word now, write the merge next cycle.
            mem_r_enable = 1'b1;
            cap_waddr_d  = bus.req_addr[31:2];
            cap_f3_d     = bus.req_funct3;
            cap_wdata_d  = bus.req_wdata[15:0];
            cap_off_d    = req_off;
            cap_old_d    = bus.mem_re_data;
            state_d      = ST_MERGE;
          end
        end
      end
      ST_MERGE: begin
        mem_w_enable = 1'b1;
        mem_address  = {cap_waddr_q, 2'b00};
        mem_wr_data  = merged_word;
        rsp_valid_d  = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_fault_q <= 1'b0;
      cap_waddr_q <= 30'h0;
      cap_f3_q    <= 3'h0;
      cap_wdata_q <= 16'h0;
      cap_off_q   <= 2'h0;
      cap_old_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_fault_q <= rsp_fault_d;
      cap_waddr_q <= cap_waddr_d;
      cap_f3_q    <= cap_f3_d;
      cap_wdata_q <= cap_wdata_d;
      cap_off_q   <= cap_off_d;
      cap_old_q   <= cap_old_d;
    end
  end

  assign bus.req_ready    = req_ready;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.rsp_fault    = rsp_fault_q;
  assign bus.mem_r_enable = mem_r_enable;
  assign bus.mem_w_enable = mem_w_enable;
  assign bus.mem_address  = mem_address;
  assign bus.mem_wr_data  = mem_wr_data;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed self-checking bench for lsu with a small word memory model
module tb_lsu;
  import lsu_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  lsu_if bus ();

  lsu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [0:15];

  assign bus.mem_re_data = mem[bus.mem_address[5:2]];

  always @(posedge clk) begin
    if (bus.mem_w_enable) mem[bus.mem_address[5:2]] <= bus.mem_wr_data;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d);
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = d;
  endtask

  task automatic idle_in();
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] exp);
    drive(1'b0, f3, a, 32'h0);
    #1;
    check({tag, " r_en"}, 32'(bus.mem_r_enable), 32'd1);
    check({tag, " w_en"}, 32'(bus.mem_w_enable), 32'd0);
    tick();
    idle_in();
    check({tag, " valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, " fault"}, 32'(bus.rsp_fault), 32'd0);
    check({tag, " rdata"}, bus.rsp_rdata, exp);
  endtask

  task automatic do_sw(input string tag, input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, F3_W, a, d);
    #1;
    check({tag, " w_en"}, 32'(bus.mem_w_enable), 32'd1);
    check({tag, " r_en"}, 32'(bus.mem_r_enable), 32'd0);
    check({tag, " wr_data"}, bus.mem_wr_data, d);
    tick();
    idle_in();
    check({tag, " valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, " rdata"}, bus.rsp_rdata, 32'h0);
  endtask

  task automatic do_subword(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] exp_word);
    drive(1'b1, f3, a, d);
    #1;
    check({tag, " rd r_en"}, 32'(bus.mem_r_enable), 32'd1);
    check({tag, " rd w_en"}, 32'(bus.mem_w_enable), 32'd0);
    tick();
    idle_in();
    #1;
    check({tag, " merge ready"}, 32'(bus.req_ready), 32'd0);
    check({tag, " merge w_en"}, 32'(bus.mem_w_enable), 32'd1);
    check({tag, " merge r_en"}, 32'(bus.mem_r_enable), 32'd0);
    check({tag, " merge addr"}, bus.mem_address, {a[31:2], 2'b00});
    check({tag, " merge data"}, bus.mem_wr_data, exp_word);
    check({tag, " merge valid"}, 32'(bus.rsp_valid), 32'd0);
    tick();
    check({tag, " valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, " ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic do_fault(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] a);
    drive(st, f3, a, 32'hDEADBEEF);
    #1;
    check({tag, " r_en"}, 32'(bus.mem_r_enable), 32'd0);
    check({tag, " w_en"}, 32'(bus.mem_w_enable), 32'd0);
    tick();
    idle_in();
    check({tag, " valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, " fault"}, 32'(bus.rsp_fault), 32'd1);
    check({tag, " rdata"}, bus.rsp_rdata, 32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle_in();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset valid", 32'(bus.rsp_valid), 32'd0);
    check("reset rdata", bus.rsp_rdata, 32'h0);
    check("reset fault", 32'(bus.rsp_fault), 32'd0);
    check("reset ready", 32'(bus.req_ready), 32'd1);
    check("idle r_en", 32'(bus.mem_r_enable), 32'd0);
    check("idle w_en", 32'(bus.mem_w_enable), 32'd0);
    @(negedge clk);

    do_sw("sw w0", 32'h0, 32'h8899AABB);
    do_sw("sw w1", 32'h4, 32'h11223344);

    do_load("lb 3", F3_B, 32'h3, 32'hFFFFFF88);
    do_load("lhu 2", F3_HU, 32'h2, 32'h00008899);
    do_load("lh 2", F3_H, 32'h2, 32'hFFFF8899);
    do_load("lbu 0", F3_BU, 32'h0, 32'h000000BB);
    do_load("lb 1", F3_B, 32'h1, 32'hFFFFFFAA);
    do_load("lw 0", F3_W, 32'h0, 32'h8899AABB);

    do_subword("sb 5", F3_B, 32'h5, 32'h123456CC, 32'h1122CC44);
    do_load("lw 4 after sb", F3_W, 32'h4, 32'h1122CC44);
    do_subword("sh 6", F3_H, 32'h6, 32'h0000BEEF, 32'hBEEFCC44);
    do_load("lh 6", F3_H, 32'h6, 32'hFFFFBEEF);

    // Back-to-back SW then LW of the same word.
    do_sw("sw w2", 32'h8, 32'hCAFEF00D);
    do_load("lw 8 after sw", F3_W, 32'h8, 32'hCAFEF00D);

`ifdef LSU_MISALIGN_TRAP_EN
    do_fault("misaligned lw", 1'b0, F3_W, 32'h6);
    do_fault("misaligned sh", 1'b1, F3_H, 32'h5);
    do_load("w1 intact", F3_W, 32'h4, 32'hBEEFCC44);
`else
    do_load("misaligned lw", F3_W, 32'h6, 32'hBEEFCC44);
    do_load("misaligned lhu", F3_HU, 32'h7, 32'h0000BEEF);
`endif

    do_fault("illegal store f3", 1'b1, 3'b100, 32'h0);
    do_fault("illegal load f3", 1'b0, 3'b011, 32'h0);
    do_load("w0 after illegal", F3_W, 32'h0, 32'h8899AABB);

    tick();
    check("no req valid", 32'(bus.rsp_valid), 32'd0);

    // Reset arrives while the SH merge write is pending.
    drive(1'b1, F3_H, 32'h0, 32'h00007777);
    tick();
    idle_in();
    #1;
    check("pre-rst merge w_en", 32'(bus.mem_w_enable), 32'd1);
    rst = 1'b1;
    #1;
    check("rst merge w_en", 32'(bus.mem_w_enable), 32'd0);
    check("rst merge ready", 32'(bus.req_ready), 32'd1);
    check("rst merge valid", 32'(bus.rsp_valid), 32'd0);
    check("rst merge rdata", bus.rsp_rdata, 32'h0);
    check("rst merge fault", 32'(bus.rsp_fault), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("post-rst valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check("post-rst valid 2", 32'(bus.rsp_valid), 32'd0);
    do_load("w0 after rst", F3_W, 32'h0, 32'h8899AABB);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
